// File: rtl/ysyx_22041461_mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041461_mem_pkg
// Description : Shared types and constants for the MEM-stage load/store unit:
//               access size codes, FSM state type, byte-strobe base masks and
//               the latched memory-op record.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041461_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [7:0] WSTRB_B = 8'h01;
    localparam logic [7:0] WSTRB_H = 8'h03;
    localparam logic [7:0] WSTRB_W = 8'h0F;
    localparam logic [7:0] WSTRB_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
    } mem_op_t;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_mask = WSTRB_B;
            SZ_H:    size_mask = WSTRB_H;
            SZ_W:    size_mask = WSTRB_W;
            default: size_mask = WSTRB_D;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041461_mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041461_mem_access_if
// Description : Data-bus interface of the load/store unit. One valid/ready
//               request channel and a single-cycle response strobe.
//   master : drives bus_req_valid/we/addr/wdata/wstrb,
//            receives bus_req_ready, bus_resp_valid, bus_resp_rdata
//   slave  : the opposite directions (memory side)
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22041461_mem_access_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wstrb;
    logic        bus_resp_valid;
    logic [63:0] bus_resp_rdata;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22041461_mem_access_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041461_lsu_align
// Description : Combinational lane logic. Shifts store data and byte strobes
//               into the 8-byte line, extracts/extends load data from a line,
//               and flags size-misaligned addresses.
//   i_size, i_unsigned, i_off : access size, zero-extend flag, addr[2:0]
//   i_wdata, i_rdata_line     : LSB-justified store data, returned bus line
//   o_wdata, o_wstrb          : lane-shifted store data and strobes
//   o_rdata, o_misaligned     : extended load value, misalignment flag
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041461_lsu_align
    import ysyx_22041461_mem_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    input  wire logic [2:0]  i_off,
    input  wire logic [63:0] i_wdata,
    input  wire logic [63:0] i_rdata_line,
    output logic      [63:0] o_wdata,
    output logic      [7:0]  o_wstrb,
    output logic      [63:0] o_rdata,
    output logic             o_misaligned
);
    logic [5:0]  w_shamt;
    logic [63:0] w_line;

    assign w_shamt = {i_off, 3'b000};
    assign o_wdata = i_wdata << w_shamt;
    assign o_wstrb = size_mask(i_size) << i_off;
    assign w_line  = i_rdata_line >> w_shamt;

    always_comb begin
        o_rdata      = w_line;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_B: o_rdata = i_unsigned ? {56'd0, w_line[7:0]}
                                       : {{56{w_line[7]}}, w_line[7:0]};
            SZ_H: begin
                o_rdata      = i_unsigned ? {48'd0, w_line[15:0]}
                                          : {{48{w_line[15]}}, w_line[15:0]};
                o_misaligned = i_off[0];
            end
            SZ_W: begin
                o_rdata      = i_unsigned ? {32'd0, w_line[31:0]}
                                          : {{32{w_line[31]}}, w_line[31:0]};
                o_misaligned = |i_off[1:0];
            end
            default: begin
                // Doubleword fills the register; nothing to extend.
                o_rdata      = w_line;
                o_misaligned = |i_off;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ysyx_22041461_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041461_mem_access
// Description : MEM-stage load/store unit. Latches one memory op, performs a
//               request + response on the data bus, stalls upstream while
//               busy and returns the extended result with a one-cycle done.
//   clk, rst          : clock, asynchronous active-high reset
//   i_flush           : kills the in-flight op (no done)
//   i_valid_in .. i_rd_in : memory op from the EXE/MEM register
//   o_stall_req       : hold upstream pipeline registers
//   o_done/o_err      : result pulse, error qualifier (misalign/timeout)
//   o_rd_out/o_rdata_out : destination register and load data
//   bus               : data-bus master port
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041461_mem_access
    import ysyx_22041461_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_flush,
    input  wire logic        i_valid_in,
    input  wire logic        i_mem_ren,
    input  wire logic        i_mem_wen,
    input  wire logic [1:0]  i_mem_size,
    input  wire logic        i_mem_unsigned,
    input  wire logic [63:0] i_addr,
    input  wire logic [63:0] i_wdata,
    input  wire logic [4:0]  i_rd_in,
    output logic             o_stall_req,
    output logic             o_done,
    output logic             o_err,
    output logic      [4:0]  o_rd_out,
    output logic      [63:0] o_rdata_out,
    ysyx_22041461_mem_access_if.master bus
);
    localparam int CNT_W = 16;

    state_t           r_state, w_next;
    mem_op_t          r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drop, r_err, r_orphan;
    logic [63:0]      r_rdata;

    logic        w_idle, w_accept, w_hs, w_resp, w_tmo;
    logic [1:0]  w_size;
    logic        w_uns;
    logic [2:0]  w_off;
    logic [63:0] w_wdata_in, w_wdata_sh, w_ld_data;
    logic [7:0]  w_wstrb;
    logic        w_misaligned;

    assign w_idle   = (r_state == ST_IDLE);
    // Gated by rst so stall_req drops immediately on an asynchronous reset.
    assign w_accept = w_idle && !rst && i_valid_in && (i_mem_ren || i_mem_wen) && !i_flush;
    assign w_hs     = (r_state == ST_REQ) && bus.bus_req_ready;
    assign w_resp   = (r_state == ST_RESP) && bus.bus_resp_valid;
    assign w_tmo    = ((r_state == ST_REQ) || (r_state == ST_RESP)) &&
                      (r_cnt >= CNT_W'(TIMEOUT_CYC - 1));

    // In IDLE the aligner sees the incoming op (misalign check at accept);
    // afterwards it sees the latched op (bus lanes, load extraction).
    assign w_size     = w_idle ? i_mem_size     : r_op.size;
    assign w_uns      = w_idle ? i_mem_unsigned : r_op.uns;
    assign w_off      = w_idle ? i_addr[2:0]    : r_op.addr[2:0];
    assign w_wdata_in = w_idle ? i_wdata        : r_op.wdata;

    ysyx_22041461_lsu_align u_align (
        .i_size       (w_size),
        .i_unsigned   (w_uns),
        .i_off        (w_off),
        .i_wdata      (w_wdata_in),
        .i_rdata_line (bus.bus_resp_rdata),
        .o_wdata      (w_wdata_sh),
        .o_wstrb      (w_wstrb),
        .o_rdata      (w_ld_data),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_misaligned ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (w_hs)         w_next = ST_RESP;  // flush here only marks drop
                else if (i_flush) w_next = ST_IDLE;
                else if (w_tmo)   w_next = ST_DONE;
            end
            ST_RESP: begin
                if (w_resp)     w_next = r_drop ? ST_IDLE : ST_DONE;
                else if (w_tmo) w_next = (r_drop || i_flush) ? ST_IDLE : ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_drop   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op.we    <= i_mem_wen;
                r_op.size  <= i_mem_size;
                r_op.uns   <= i_mem_unsigned;
                r_op.addr  <= i_addr;
                r_op.wdata <= i_wdata;
                r_op.rd    <= i_rd_in;
                r_err      <= w_misaligned;
                r_rdata    <= '0;
                r_drop     <= 1'b0;
                r_cnt      <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_RESP)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Once the request is on the bus a flush cannot cancel it; the
            // response must still be consumed, so only remember to discard it.
            if ((w_hs || (r_state == ST_RESP)) && i_flush) r_drop <= 1'b1;

            if (w_resp) begin
                r_rdata <= r_op.we ? 64'd0 : w_ld_data;
                r_err   <= 1'b0;
            end else if (w_tmo && !w_hs) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end

            // A response abandoned by timeout may still show up later.
            if ((r_state == ST_RESP) && w_tmo && !w_resp) r_orphan <= 1'b1;
            else if (bus.bus_resp_valid && (r_state != ST_RESP)) r_orphan <= 1'b0;
        end
    end

    assign o_stall_req = (r_state == ST_REQ) || (r_state == ST_RESP) || w_accept;
    assign o_done      = (r_state == ST_DONE);
    assign o_err       = o_done && r_err;
    assign o_rd_out    = o_done ? r_op.rd : 5'd0;
    assign o_rdata_out = o_done ? r_rdata : 64'd0;

    assign bus.bus_req_valid = (r_state == ST_REQ);
    assign bus.bus_req_we    = (r_state == ST_REQ) && r_op.we;
    assign bus.bus_req_addr  = (r_state == ST_REQ) ? {r_op.addr[63:3], 3'b000} : 64'd0;
    assign bus.bus_req_wdata = (r_state == ST_REQ) ? w_wdata_sh : 64'd0;
    assign bus.bus_req_wstrb = ((r_state == ST_REQ) && r_op.we) ? w_wstrb : 8'd0;

    a_resp_only_in_resp: assert property (@(posedge clk) disable iff (rst)
        bus.bus_resp_valid |-> ((r_state == ST_RESP) || r_orphan))
        else $error("bus_resp_valid outside RESP");
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041461_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041461_mem_access
// Description : Self-checking bench for the MEM-stage load/store unit:
//               directed scenarios plus randomized ops checked against a
//               byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041461_mem_access;
    import ysyx_22041461_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, valid_in = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic        mem_unsigned = 1'b0;
    logic [63:0] addr = '0, wdata = '0;
    logic [4:0]  rd_in = '0;
    logic        stall_req, done, err;
    logic [4:0]  rd_out;
    logic [63:0] rdata_out;

    int total = 0;
    int bad   = 0;

    ysyx_22041461_mem_access_if bus_if ();

    ysyx_22041461_mem_access #(.TIMEOUT_CYC(255)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush),
        .i_valid_in     (valid_in),
        .i_mem_ren      (mem_ren),
        .i_mem_wen      (mem_wen),
        .i_mem_size     (mem_size),
        .i_mem_unsigned (mem_unsigned),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .i_rd_in        (rd_in),
        .o_stall_req    (stall_req),
        .o_done         (done),
        .o_err          (err),
        .o_rd_out       (rd_out),
        .o_rdata_out    (rdata_out),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-wise) ----------------
    function automatic logic [63:0] m_load(input logic [63:0] line, input int off,
                                           input int nb, input bit uns);
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = line[8*(off+i) +: 8];
        if (!uns && nb < 8 && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] m_strb(input int off, input int nb);
        logic [7:0] s = '0;
        for (int i = 0; i < nb; i++) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int off);
        logic [63:0] w = '0;
        for (int b = 0; b < 8; b++)
            if (b >= off) w[8*b +: 8] = wd[8*(b-off) +: 8];
        return w;
    endfunction

    // Complete one op from IDLE; returns latency (accept cycle = 0) and rdata.
    task automatic run_op(input string tag, input bit we, input logic [1:0] sz,
                          input bit uns, input logic [63:0] a, input logic [63:0] wd,
                          input logic [4:0] rd, input logic [63:0] line,
                          input int rdy_dly, input int rsp_dly,
                          output int lat, output logic [63:0] got);
        int nb, off;
        bit mis;
        nb  = 1 << sz;
        off = int'(a[2:0]);
        mis = (off % nb) != 0;
        lat = 0;
        valid_in = 1'b1; mem_ren = !we; mem_wen = we; mem_size = sz;
        mem_unsigned = uns; addr = a; wdata = wd; rd_in = rd;
        #1;
        chk({tag, ".accept_stall"}, stall_req, 1'b1);
        chk({tag, ".accept_noreq"}, bus_if.bus_req_valid, 1'b0);
        step(); lat++;
        if (!mis) begin
            for (int i = 0; i < rdy_dly; i++) begin
                chk({tag, ".req_valid"}, bus_if.bus_req_valid, 1'b1);
                step(); lat++;
            end
            chk({tag, ".req_valid"}, bus_if.bus_req_valid, 1'b1);
            chk({tag, ".req_we"},    bus_if.bus_req_we, we);
            chk({tag, ".req_addr"},  bus_if.bus_req_addr, {a[63:3], 3'b000});
            chk({tag, ".req_wdata"}, bus_if.bus_req_wdata, m_wdata(wd, off));
            chk({tag, ".req_wstrb"}, bus_if.bus_req_wstrb, we ? m_strb(off, nb) : 8'h00);
            bus_if.bus_req_ready = 1'b1;
            step(); lat++;
            bus_if.bus_req_ready = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                chk({tag, ".resp_wait"}, {done, stall_req, bus_if.bus_req_valid}, 3'b010);
                step(); lat++;
            end
            bus_if.bus_resp_valid = 1'b1;
            bus_if.bus_resp_rdata = line;
            step(); lat++;
            bus_if.bus_resp_valid = 1'b0;
        end
        got = rdata_out;
        chk({tag, ".done"},  done, 1'b1);
        chk({tag, ".err"},   err, mis);
        chk({tag, ".rd"},    rd_out, rd);
        chk({tag, ".rdata"}, rdata_out, (mis || we) ? 64'd0 : m_load(line, off, nb, uns));
        chk({tag, ".stall"}, stall_req, 1'b0);
        valid_in = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        step();
        chk({tag, ".done_once"}, done, 1'b0);
    endtask

    initial begin
        int          lat, n;
        logic [63:0] got;
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b0;
        bus_if.bus_resp_rdata = '0;

        // Reset state
        repeat (2) step();
        chk("rst.stall", stall_req, 1'b0);
        chk("rst.done",  done, 1'b0);
        chk("rst.breq",  bus_if.bus_req_valid, 1'b0);
        rst = 1'b0;
        step();
        chk("idle.outs", {done, err, rd_out, rdata_out, stall_req}, '0);

        // LW: done at cycle 3, sign-extended
        run_op("lw", 1'b0, SZ_W, 1'b0, 64'h8000_0004, 64'd0, 5'd5,
               64'hDEADBEEF_00000000, 0, 0, lat, got);
        chk("lw.latency", lat, 3);
        chk("lw.value", got, 64'hFFFFFFFF_DEADBEEF);

        // SB at byte 3
        run_op("sb", 1'b1, SZ_B, 1'b0, 64'h8000_0003, 64'hAB, 5'd6,
               64'h1234, 1, 1, lat, got);

        // LH misaligned: no bus, done next cycle
        run_op("lh_mis", 1'b0, SZ_H, 1'b0, 64'h8000_0001, 64'd0, 5'd9,
               64'd0, 0, 0, lat, got);
        chk("lh_mis.latency", lat, 1);

        // Timeout with ready held low
        valid_in = 1'b1; mem_ren = 1'b1; mem_size = SZ_W; addr = 64'h3000; rd_in = 5'd7;
        step();
        n = 0;
        while (!done && n < 300) begin step(); n++; end
        chk("tmo_req.cycles", n, 255);
        chk("tmo_req.err",    err, 1'b1);
        chk("tmo_req.rdata",  rdata_out, 64'd0);
        chk("tmo_req.breq",   bus_if.bus_req_valid, 1'b0);
        valid_in = 1'b0; mem_ren = 1'b0;
        repeat (40) step();
        chk("tmo_req.quiet", {done, stall_req, bus_if.bus_req_valid}, 3'b000);

        // Timeout in RESP, then the late response is ignored
        valid_in = 1'b1; mem_ren = 1'b1; mem_size = SZ_D; addr = 64'h4000; rd_in = 5'd8;
        step();
        bus_if.bus_req_ready = 1'b1;
        step(); n = 1;
        bus_if.bus_req_ready = 1'b0;
        while (!done && n < 300) begin step(); n++; end
        chk("tmo_resp.cycles", n, 255);
        chk("tmo_resp.err",    err, 1'b1);
        valid_in = 1'b0; mem_ren = 1'b0;
        step();
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_resp_rdata = 64'hFFFF;
        step();
        bus_if.bus_resp_valid = 1'b0;
        chk("late_resp.ignored", {done, stall_req, rdata_out}, '0);

        // Flush in REQ before handshake
        valid_in = 1'b1; mem_ren = 1'b1; mem_size = SZ_D; addr = 64'h5000;
        step();
        flush = 1'b1; valid_in = 1'b0; mem_ren = 1'b0;
        step();
        flush = 1'b0;
        chk("flush_req.idle", {done, stall_req, bus_if.bus_req_valid}, 3'b000);
        step();
        chk("flush_req.nodone", done, 1'b0);

        // Flush in RESP of an LD: response consumed, no done
        valid_in = 1'b1; mem_ren = 1'b1; mem_size = SZ_D; addr = 64'h6000;
        step();
        bus_if.bus_req_ready = 1'b1;
        step();
        bus_if.bus_req_ready = 1'b0;
        valid_in = 1'b0; mem_ren = 1'b0; flush = 1'b1;
        #1;
        chk("flush_resp.stall", stall_req, 1'b1);
        step();
        flush = 1'b0;
        chk("flush_resp.wait", {done, stall_req}, 2'b01);
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_resp_rdata = 64'h1111;
        step();
        bus_if.bus_resp_valid = 1'b0;
        chk("flush_resp.nodone", {done, stall_req}, 2'b00);
        step();
        chk("flush_resp.nodone2", done, 1'b0);
        run_op("lbu", 1'b0, SZ_B, 1'b1, 64'h8000_0007, 64'd0, 5'd3,
               64'h8000_0000_0000_0000, 0, 0, lat, got);
        chk("lbu.value", got, 64'h80);

        // Reset in REQ: outputs fall without a clock edge
        valid_in = 1'b1; mem_ren = 1'b1; mem_size = SZ_W; addr = 64'h7000;
        step();
        chk("rst_req.pre", bus_if.bus_req_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req.breq",  bus_if.bus_req_valid, 1'b0);
        chk("rst_req.stall", stall_req, 1'b0);
        valid_in = 1'b0; mem_ren = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rst_req.idle", {done, stall_req, bus_if.bus_req_valid}, 3'b000);

        // Randomized ops
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  sz;
            logic [63:0] a, wd, line;
            int          off;
            bit          we;
            sz  = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
            a    = {$urandom, $urandom};
            a    = {a[63:3], 3'(off)};
            wd   = {$urandom, $urandom};
            line = {$urandom, $urandom};
            run_op("rnd", we, sz, 1'($urandom_range(0, 1)), a, wd, 5'($urandom),
                   line, $urandom_range(0, 3), $urandom_range(0, 3), lat, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
